irq_controller: RTL and testbench

Parametrised interrupt controller for the CPU core. It generalises the fixed 8-line IRQ logic to NUM_IRQ channels with:
- per-channel edge or level sensing;
- 2-FF pin synchronisers;
- fixed or round-robin priority;
- a configurable vector format.

The block sits between the external IRQ pins and the microcode sequencer. It provides `irq_status`, `irq_masks`, `irq_vector` and `int_pending`, and is driven by microcode control strobes. It is fully synchronous, replacing the asynchronous per-pin DFFs.

---
 rtl/irq_controller.sv | 156 +++++++++++++++
 tb/tb_irq_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Interrupt controller with NUM_IRQ channels, 2-FF pin synchronisers, edge/level sensing,
// fixed or round-robin priority and a base+shifted-index vector format.
module irq_channel #(
  parameter bit LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic ack_hit,
  input  logic clear_all,
  output logic pending
);
  logic s0_q, s0_d, s1_q, s1_d, h_q, h_d, pend_q, pend_d, rise;

  always_comb begin
    s0_d = pin;
    s1_d = s0_q;
    h_d  = s1_q;
    rise = s1_q & ~h_q;
    // A rise beats a same-cycle ack so a fresh edge is never dropped.
    if (LEVEL)          pend_d = s1_q;
    else if (clear_all) pend_d = 1'b0;
    else if (rise)      pend_d = 1'b1;
    else if (ack_hit)   pend_d = 1'b0;
    else                pend_d = pend_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      h_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      h_q    <= h_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
endmodule

module irq_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter int          VECTOR_W     = 8,
  parameter int          VECTOR_SHIFT = 1,
  parameter int          VECTOR_BASE  = 0,
  parameter logic [31:0] LEVEL_MASK   = 32'h0,
  parameter bit          RR_EN        = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_pins,
  input  logic                irq_en,
  input  logic                masks_wrt_n,
  input  logic [NUM_IRQ-1:0]  masks_in,
  input  logic                vector_wrt_n,
  input  logic                int_ack,
  input  logic                clear_all,
  output logic [NUM_IRQ-1:0]  irq_status,
  output logic [NUM_IRQ-1:0]  irq_masks,
  output logic [VECTOR_W-1:0] irq_vector,
  output logic                vector_valid,
  output logic                int_pending
);
  localparam int                IDX_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_IRQ - 1);
  localparam logic [VECTOR_W-1:0] BASE   = VECTOR_W'(VECTOR_BASE);

  logic [NUM_IRQ-1:0]   pending, ack_hit, masked;
  logic [NUM_IRQ-1:0]   status_q, status_d, masks_q, masks_d;
  logic                 request_q, request_d, vvalid_q, vvalid_d, ack_ok;
  logic [VECTOR_W-1:0]  vec_q, vec_d, ack_off, ack_idx;
  logic [IDX_W-1:0]     last_q, last_d, start, win;
  logic [2*NUM_IRQ-1:0] rot;
  logic [IDX_W:0]       sum;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
    irq_channel #(.LEVEL(LEVEL_MASK[gi])) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (irq_pins[gi]),
      .ack_hit   (ack_hit[gi]),
      .clear_all (clear_all),
      .pending   (pending[gi])
    );
  end

  // Winner search: rotate masked so the search start lands at bit 0, take the
  // lowest set bit, then map back modulo NUM_IRQ. Fixed mode starts at 0.
  always_comb begin
    masked = status_q & masks_q;
    start  = '0;
    if (RR_EN && (last_q != LAST_RST)) start = last_q + 1'b1;
    rot = {masked, masked} >> start;
    sum = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (rot[k]) sum = {1'b0, start} + (IDX_W+1)'(k);
    if (sum >= (IDX_W+1)'(NUM_IRQ)) sum = sum - (IDX_W+1)'(NUM_IRQ);
    win = sum[IDX_W-1:0];
  end

  // Ack decodes the currently latched vector, never the one being written.
  always_comb begin
    ack_off = vec_q - BASE;
    ack_idx = ack_off >> VECTOR_SHIFT;
    ack_ok  = int_ack && vvalid_q && ({1'b0, ack_idx} < (VECTOR_W+1)'(NUM_IRQ));
    for (int i = 0; i < NUM_IRQ; i++)
      ack_hit[i] = ack_ok && ({1'b0, ack_idx} == (VECTOR_W+1)'(i));
  end

  always_comb begin
    status_d  = pending;
    request_d = |masked;
    masks_d   = masks_wrt_n ? masks_q : masks_in;
    vec_d     = vec_q;
    vvalid_d  = vvalid_q;
    last_d    = last_q;
    if (!vector_wrt_n) begin
      if (|masked) begin
        vec_d    = BASE + (VECTOR_W'(win) << VECTOR_SHIFT);
        vvalid_d = 1'b1;
        if (RR_EN) last_d = win;
      end else begin
        vec_d    = BASE;
        vvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q  <= '0;
      masks_q   <= '0;
      request_q <= 1'b0;
      vec_q     <= '0;
      vvalid_q  <= 1'b0;
      last_q    <= LAST_RST;
    end else begin
      status_q  <= status_d;
      masks_q   <= masks_d;
      request_q <= request_d;
      vec_q     <= vec_d;
      vvalid_q  <= vvalid_d;
      last_q    <= last_d;
    end
  end

  assign irq_status   = status_q;
  assign irq_masks    = masks_q;
  assign irq_vector   = vec_q;
  assign vector_valid = vvalid_q;
  assign int_pending  = request_q & irq_en;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a fixed-priority table plus hand sequences
// for round-robin, level channels and mid-operation reset.
module tb_irq_controller;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] pins = '0, masks_in = '0;
  logic       irq_en = 1'b1, masks_wrt_n = 1'b1, vector_wrt_n = 1'b1, int_ack = 1'b0, clear_all = 1'b0;

  logic [7:0] st_f, mk_f, vec_f, st_r, mk_r, vec_r, st_l, mk_l, vec_l;
  logic       vv_f, ip_f, vv_r, ip_r, vv_l, ip_l;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  irq_controller u_fix (
    .clk(clk), .rst_n(rst_n), .irq_pins(pins), .irq_en(irq_en), .masks_wrt_n(masks_wrt_n),
    .masks_in(masks_in), .vector_wrt_n(vector_wrt_n), .int_ack(int_ack), .clear_all(clear_all),
    .irq_status(st_f), .irq_masks(mk_f), .irq_vector(vec_f), .vector_valid(vv_f), .int_pending(ip_f));

  irq_controller #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .irq_pins(pins), .irq_en(irq_en), .masks_wrt_n(masks_wrt_n),
    .masks_in(masks_in), .vector_wrt_n(vector_wrt_n), .int_ack(int_ack), .clear_all(clear_all),
    .irq_status(st_r), .irq_masks(mk_r), .irq_vector(vec_r), .vector_valid(vv_r), .int_pending(ip_r));

  irq_controller #(.LEVEL_MASK(32'h1)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq_pins(pins), .irq_en(irq_en), .masks_wrt_n(masks_wrt_n),
    .masks_in(masks_in), .vector_wrt_n(vector_wrt_n), .int_ack(int_ack), .clear_all(clear_all),
    .irq_status(st_l), .irq_masks(mk_l), .irq_vector(vec_l), .vector_valid(vv_l), .int_pending(ip_l));

  typedef struct {
    logic [7:0] pins; logic mw_n; logic [7:0] min; logic vw_n, ack, clr, en;
    logic [7:0] st; logic ip; logic [7:0] vec; logic vv;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input logic [7:0] p, input logic mw, input logic [7:0] mi,
                     input logic vw, input logic ak, input logic cl, input logic en,
                     input logic [7:0] st, input logic ip, input logic [7:0] vc, input logic vv);
    vec_t t;
    t.pins = p; t.mw_n = mw; t.min = mi; t.vw_n = vw; t.ack = ak; t.clr = cl; t.en = en;
    t.st = st; t.ip = ip; t.vec = vc; t.vv = vv;
    tv.push_back(t);
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pins = '0; masks_wrt_n = 1'b1; masks_in = '0; vector_wrt_n = 1'b1;
    int_ack = 1'b0; clear_all = 1'b0; irq_en = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rr_exp [3];
    rr_exp[0] = 8'h00; rr_exp[1] = 8'h02; rr_exp[2] = 8'h0E;

    //   pins mw_n min vw ak cl en   st  ip vec vv
    row(8'h00, 0, 8'hFF, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0);
    row(8'h08, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0);
    row(8'h08, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0);
    row(8'h08, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h08, 0, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h08, 1, 8'h00, 0);
    row(8'h00, 1, 8'h00, 0, 0, 0, 1, 8'h08, 1, 8'h06, 1);
    row(8'h00, 1, 8'h00, 1, 1, 0, 1, 8'h08, 1, 8'h06, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h06, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h06, 1);
    // pins 5 and 2 together
    row(8'h24, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h06, 1);
    row(8'h24, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h06, 1);
    row(8'h24, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h06, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h24, 0, 8'h06, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h24, 1, 8'h06, 1);
    row(8'h00, 1, 8'h00, 0, 0, 0, 1, 8'h24, 1, 8'h04, 1);
    row(8'h00, 1, 8'h00, 1, 1, 0, 1, 8'h24, 1, 8'h04, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h20, 1, 8'h04, 1);
    row(8'h00, 1, 8'h00, 0, 0, 0, 1, 8'h20, 1, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 1, 1, 0, 1, 8'h20, 1, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0A, 1);
    // channel 6: second rise lands on the same edge as the ack for channel 6
    row(8'h40, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0A, 1);
    row(8'h40, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0A, 1);
    row(8'h40, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h40, 0, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h40, 1, 8'h0A, 1);
    row(8'h00, 1, 8'h00, 0, 0, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h40, 1, 8'h00, 1, 0, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h40, 1, 8'h00, 1, 0, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h40, 1, 8'h00, 1, 1, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 1, 0, 1, 8'h40, 1, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0C, 1);
    // masks = 0 with pin 4, invalid vector, ignored ack, late unmask, irq_en, clear_all
    row(8'h10, 0, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0C, 1);
    row(8'h10, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0C, 1);
    row(8'h10, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h10, 0, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h10, 0, 8'h0C, 1);
    row(8'h00, 1, 8'h00, 0, 0, 0, 1, 8'h10, 0, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 1, 0, 1, 8'h10, 0, 8'h00, 0);
    row(8'h00, 0, 8'h10, 1, 0, 0, 1, 8'h10, 0, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h10, 1, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 1, 0, 8'h10, 0, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 8'h00, 0);
    row(8'h00, 1, 8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h00, 0);

    // Reset state of every instance
    idle();
    rst_n = 1'b0;
    step(); step();
    chk("rst fix status", st_f, 0);  chk("rst fix masks", mk_f, 0);
    chk("rst fix vector", vec_f, 0); chk("rst fix valid", vv_f, 0);
    chk("rst fix intp", ip_f, 0);
    chk("rst rr status", st_r, 0);   chk("rst rr vector", vec_r, 0);
    chk("rst lvl status", st_l, 0);  chk("rst lvl intp", ip_l, 0);
    rst_n = 1'b1;

    // Fixed-priority table on u_fix
    for (int i = 0; i < tv.size(); i++) begin
      pins = tv[i].pins; masks_wrt_n = tv[i].mw_n; masks_in = tv[i].min;
      vector_wrt_n = tv[i].vw_n; int_ack = tv[i].ack; clear_all = tv[i].clr; irq_en = tv[i].en;
      step();
      chk($sformatf("row%0d status", i), st_f, tv[i].st);
      chk($sformatf("row%0d intp", i), ip_f, tv[i].ip);
      chk($sformatf("row%0d vector", i), vec_f, tv[i].vec);
      chk($sformatf("row%0d valid", i), vv_f, tv[i].vv);
    end
    idle();

    // Reset mid-pending on u_fix
    pins = 8'h02; masks_wrt_n = 1'b0; masks_in = 8'hFF; step();
    masks_wrt_n = 1'b1; step(); step();
    pins = '0; step(); step();
    vector_wrt_n = 1'b0; step(); vector_wrt_n = 1'b1;
    chk("pre-rst status", st_f, 8'h02); chk("pre-rst intp", ip_f, 1);
    chk("pre-rst vector", vec_f, 8'h02);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid-rst status", st_f, 0); chk("mid-rst masks", mk_f, 0);
    chk("mid-rst vector", vec_f, 0); chk("mid-rst valid", vv_f, 0);
    chk("mid-rst intp", ip_f, 0);
    step(); step(); step();
    chk("post-rst status", st_f, 0); chk("post-rst intp", ip_f, 0);

    // Round-robin on u_rr
    do_reset();
    pins = 8'h83; masks_wrt_n = 1'b0; masks_in = 8'hFF; step();
    masks_wrt_n = 1'b1; step(); step();
    pins = '0; step(); step();
    chk("rr status", st_r, 8'h83); chk("rr intp", ip_r, 1);
    for (int n = 0; n < 3; n++) begin
      vector_wrt_n = 1'b0; step(); vector_wrt_n = 1'b1;
      chk($sformatf("rr vector %0d", n), vec_r, rr_exp[n]);
      chk($sformatf("rr valid %0d", n), vv_r, 1);
      int_ack = 1'b1; step(); int_ack = 1'b0;
      step(); step();
    end
    chk("rr drained", st_r, 0);
    pins = 8'h01; step(); step(); step(); pins = '0; step();
    vector_wrt_n = 1'b0; step(); vector_wrt_n = 1'b1;
    chk("rr wrap vector", vec_r, 8'h00);
    pins = 8'h04; step(); step(); step(); pins = '0; step();
    chk("rr status 0+2", st_r, 8'h05);
    vector_wrt_n = 1'b0; step(); vector_wrt_n = 1'b1;
    chk("rr skip-last vector", vec_r, 8'h04);

    // Level channel 0 on u_lvl
    do_reset();
    pins = 8'h01; masks_wrt_n = 1'b0; masks_in = 8'hFF; step();
    masks_wrt_n = 1'b1; step(); step(); step();
    chk("lvl intp early", ip_l, 0);
    step();
    chk("lvl status", st_l, 8'h01); chk("lvl intp", ip_l, 1);
    vector_wrt_n = 1'b0; step(); vector_wrt_n = 1'b1;
    chk("lvl vector", vec_l, 8'h00); chk("lvl valid", vv_l, 1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    clear_all = 1'b1; step(); clear_all = 1'b0;
    step();
    chk("lvl after ack/clr", st_l, 8'h01); chk("lvl intp held", ip_l, 1);
    pins = '0; step(); step(); step();
    chk("lvl drop +3", st_l, 8'h01);
    step();
    chk("lvl drop +4", st_l, 8'h00);
    step();
    chk("lvl intp drop", ip_l, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
